regfile_wb: RTL and testbench

32-entry by 32-bit register file that forms the write-back stage of the KGP_RISC datapath. Its write-data input is driven directly by the 32-bit 4:1 write-back select mux, which chooses between ALU result, memory data, PC+4 and immediate. It provides two bypassed combinational read ports to decode/execute. A per-register pending scoreboard lets the control unit mark destinations of multi-cycle operations and stall on RAW hazards.

---
 rtl/regfile_wb.sv | 81 ++++++++
 tb/tb_regfile_wb.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb.sv
// Write-back register file for KGP_RISC: 2 bypassed combinational read ports,
// 1 write port fed by the write-back select mux, and a per-register pending scoreboard.
module regfile_wb #(
  parameter int NREG = 32,
  parameter int W    = 32,
  parameter int AW   = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  output logic [W-1:0]  rs_data,
  output logic [W-1:0]  rt_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          lock_en,
  input  logic [AW-1:0] lock_addr,
  output logic          rs_busy,
  output logic          rt_busy,
  output logic          hazard
);

  logic [W-1:0]    regs [NREG];
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;

  logic wr_act;
  logic lock_act;
  logic rs_hit;
  logic rt_hit;

  assign wr_act   = wr_en   && (wr_addr   != '0);
  assign lock_act = lock_en && (lock_addr != '0);
  assign rs_hit   = wr_en && (wr_addr == rs_addr);
  assign rt_hit   = wr_en && (wr_addr == rt_addr);

  // A retiring write clears the bit first; a lock in the same cycle then
  // re-arms it, so a newer outstanding load to the same register wins.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pending_nxt = pending;
    if (wr_act)   pending_nxt[wr_addr]   = 1'b0;
    if (lock_act) pending_nxt[lock_addr] = 1'b1;
  end

  // NOTE: the array is reset explicitly because reset must clear architectural
  // state immediately; this costs a flop-based array rather than a RAM macro.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      pending <= '0;
    end else begin
      if (wr_act) regs[wr_addr] <= wr_data;
      pending <= pending_nxt;
    end
  end

  // Register 0 is hardwired to zero and never busy regardless of write/lock traffic.
  always_comb begin
    rs_data = '0;
    rs_busy = 1'b0;
    if (rs_addr != '0) begin
      rs_data = rs_hit ? wr_data : regs[rs_addr];
      rs_busy = pending[rs_addr] && !rs_hit;
    end
  end

  always_comb begin
    rt_data = '0;
    rt_busy = 1'b0;
    if (rt_addr != '0) begin
      rt_data = rt_hit ? wr_data : regs[rt_addr];
      rt_busy = pending[rt_addr] && !rt_hit;
    end
  end

  assign hazard = rs_busy | rt_busy;

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: directed scenarios plus randomized traffic
// against an array/bit-vector reference model of the register file rules.
module tb_regfile_wb;

  localparam int NREG = 32;
  localparam int W    = 32;
  localparam int AW   = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs_addr, rt_addr, wr_addr, lock_addr;
  logic [W-1:0]  rs_data, rt_data, wr_data;
  logic          wr_en, lock_en;
  logic          rs_busy, rt_busy, hazard;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W-1:0] mregs [NREG];
  bit           mpend [NREG];

  regfile_wb #(.NREG(NREG), .W(W), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .lock_en(lock_en), .lock_addr(lock_addr),
    .rs_busy(rs_busy), .rt_busy(rt_busy), .hazard(hazard)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NREG; i++) begin
      mregs[i] = '0;
      mpend[i] = 1'b0;
    end
  endfunction

  function automatic logic [W-1:0] exp_data(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (wr_en && wr_addr == a) return wr_data;
    return mregs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    return mpend[a] && !(wr_en && wr_addr == a);
  endfunction

  // Check all outputs mid-cycle, then apply the clock edge to the model.
  task automatic step();
    logic eb_rs, eb_rt;
    @(negedge clk);
    eb_rs = exp_busy(rs_addr);
    eb_rt = exp_busy(rt_addr);
    check("rs_data", rs_data, exp_data(rs_addr));
    check("rt_data", rt_data, exp_data(rt_addr));
    check("rs_busy", {31'b0, rs_busy}, {31'b0, eb_rs});
    check("rt_busy", {31'b0, rt_busy}, {31'b0, eb_rt});
    check("hazard",  {31'b0, hazard},  {31'b0, eb_rs | eb_rt});
    @(posedge clk);
    if (rst) begin
      if (wr_en && wr_addr != 0) begin
        mregs[wr_addr] = wr_data;
        mpend[wr_addr] = 1'b0;
      end
      if (lock_en && lock_addr != 0) mpend[lock_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; lock_en = 1'b0;
    wr_addr = '0; lock_addr = '0; wr_data = '0;
  endtask

  initial begin
    rst = 1'b0;
    rs_addr = '0; rt_addr = '0;
    idle();
    model_reset();
    #1;
    check("reset_rs_data", rs_data, '0);
    check("reset_hazard", {31'b0, hazard}, '0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Mid-run asynchronous reset clears data and pending immediately.
    wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    lock_en = 1'b1; lock_addr = 5;
    rs_addr = 5; rt_addr = 0;
    step();
    idle();
    #1;
    check("pre_reset_data", rs_data, 32'hDEADBEEF);
    check("pre_reset_hazard", {31'b0, hazard}, 32'd1);
    rst = 1'b0;
    #1;
    model_reset();
    check("async_reset_data", rs_data, '0);
    check("async_reset_hazard", {31'b0, hazard}, '0);
    // A write attempted while reset is held must be discarded.
    wr_en = 1'b1; wr_addr = 5; wr_data = 32'h11111111;
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    step();
    check("post_reset_data", rs_data, '0);

    // Write with same-cycle bypass, then read from storage.
    wr_en = 1'b1; wr_addr = 3; wr_data = 32'h12345678; rs_addr = 3;
    #1;
    check("bypass", rs_data, 32'h12345678);
    step();
    idle();
    #1;
    check("stored", rs_data, 32'h12345678);
    step();

    // Register 0 ignores writes and locks.
    wr_en = 1'b1; wr_addr = 0; wr_data = 32'hFFFFFFFF;
    lock_en = 1'b1; lock_addr = 0;
    rs_addr = 0; rt_addr = 0;
    #1;
    check("r0_rs_data", rs_data, '0);
    check("r0_rt_data", rt_data, '0);
    step();
    idle();
    #1;
    check("r0_rs_busy", {31'b0, rs_busy}, '0);
    step();

    // Scoreboard lock, stall, and same-cycle release by the retiring write.
    lock_en = 1'b1; lock_addr = 7; rt_addr = 7;
    #1;
    check("lock_not_yet", {31'b0, rt_busy}, '0);
    step();
    idle();
    #1;
    check("locked_rt_busy", {31'b0, rt_busy}, 32'd1);
    check("locked_hazard", {31'b0, hazard}, 32'd1);
    step();
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'hA5A5A5A5;
    #1;
    check("release_busy", {31'b0, rt_busy}, '0);
    check("release_data", rt_data, 32'hA5A5A5A5);
    step();
    idle();
    #1;
    check("released_after", {31'b0, hazard}, '0);
    step();

    // Simultaneous write+lock on the same register: lock wins.
    wr_en = 1'b1; wr_addr = 9; wr_data = 32'h00000042;
    lock_en = 1'b1; lock_addr = 9; rs_addr = 9; rt_addr = 10;
    step();
    idle();
    #1;
    check("wl_same_data", rs_data, 32'h42);
    check("wl_same_busy", {31'b0, rs_busy}, 32'd1);
    step();
    // Lock one register, write another.
    wr_en = 1'b1; wr_addr = 10; wr_data = 32'hCAFEF00D;
    lock_en = 1'b1; lock_addr = 9;
    step();
    idle();
    #1;
    check("wl_diff_data", rt_data, 32'hCAFEF00D);
    check("wl_diff_busy10", {31'b0, rt_busy}, '0);
    check("wl_diff_busy9", {31'b0, rs_busy}, 32'd1);
    step();

    // Dual-port sweep; retire any pending entries first via the writes.
    for (int i = 1; i < NREG; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = i * 32'h01010101;
      step();
    end
    idle();
    for (int a = 0; a < NREG; a++) begin
      for (int b = 0; b < NREG; b++) begin
        rs_addr = AW'(a); rt_addr = AW'(b);
        #1;
        check("sweep_rs", rs_data, a * 32'h01010101);
        check("sweep_rt", rt_data, b * 32'h01010101);
        check("sweep_hz", {31'b0, hazard}, '0);
      end
    end

    // Randomized traffic, addresses biased to a small window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      wr_en     = ($urandom_range(0, 99) < 40);
      lock_en   = ($urandom_range(0, 99) < 30);
      wr_addr   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      lock_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      rs_addr   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      rt_addr   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      wr_data   = $urandom;
      step();
    end
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
